// File: rtl/drum_mac_acc_if.sv
// Product-in / result-out handshake bundle for drum_mac_acc.
// master = upstream producer plus downstream consumer; slave = the accumulator block.
interface drum_mac_acc_if #(
   parameter int unsigned PW    = 8,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_cnt, out_ovf
   );
endinterface

// File: rtl/drum_mac_acc.sv
// Saturating signed dot-product accumulator behind the DRUM multiplier.
// Define DRUM_ONES_FIX_EN to add +1 to negative products (inversion-coded negatives -> two's complement).
module drum_mac_acc #(
   parameter int unsigned PW    = 8,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   drum_mac_acc_if.slave bus
);
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf_r;

   logic             beat;
   logic [ACC_W-1:0] acc_base;
   logic [CNT_W-1:0] cnt_base;
   logic             ovf_base;
   logic [EXT_W-1:0] ext_prod;
   logic [EXT_W-1:0] sum;
   logic [ACC_W-1:0] sat_sum;
   logic             sat_hit;
   logic [CNT_W-1:0] cnt_next;

   // Only combinational path: a consume this cycle frees the result register.
   assign bus.in_ready = ~bus.out_valid | bus.out_ready;
   assign beat         = bus.in_valid & bus.in_ready;

   // IDLE always starts a vector from zero, regardless of leftover register contents.
   always_comb begin
      acc_base = '0;
      cnt_base = '0;
      ovf_base = 1'b0;
      if (state == RUN) begin
         acc_base = acc;
         cnt_base = cnt;
         ovf_base = ovf_r;
      end

      ext_prod = {{(EXT_W-PW){bus.in_prod[PW-1]}}, bus.in_prod};
`ifdef DRUM_ONES_FIX_EN
      ext_prod = ext_prod + EXT_W'(bus.in_prod[PW-1]);
`endif

      sum = {acc_base[ACC_W-1], acc_base} + ext_prod;

      // Top two bits of the widened sum disagree exactly when the ACC_W range is exceeded.
      sat_sum = sum[ACC_W-1:0];
      sat_hit = 1'b0;
      case ({sum[ACC_W], sum[ACC_W-1]})
         2'b01: begin
            sat_sum = ACC_MAX;
            sat_hit = 1'b1;
         end
         2'b10: begin
            sat_sum = ACC_MIN;
            sat_hit = 1'b1;
         end
         default: ;
      endcase

      cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         ovf_r         <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_acc   <= '0;
         bus.out_cnt   <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (beat) begin
            if (bus.in_last) begin
               // Load result and clear the vector state in the same edge.
               bus.out_acc   <= sat_sum;
               bus.out_cnt   <= cnt_next;
               bus.out_ovf   <= ovf_base | sat_hit;
               bus.out_valid <= 1'b1;
               acc           <= '0;
               cnt           <= '0;
               ovf_r         <= 1'b0;
               state         <= IDLE;
            end else begin
               acc   <= sat_sum;
               cnt   <= cnt_next;
               ovf_r <= ovf_base | sat_hit;
               state <= RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_drum_mac_acc.sv
// Directed self-checking bench for drum_mac_acc (16-bit and 8-bit accumulator builds).
module tb_drum_mac_acc;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   drum_mac_acc_if #(.PW(8), .ACC_W(16), .CNT_W(8)) b16 ();
   drum_mac_acc_if #(.PW(8), .ACC_W(8),  .CNT_W(8)) b8 ();

   drum_mac_acc #(.PW(8), .ACC_W(16), .CNT_W(8)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
   drum_mac_acc #(.PW(8), .ACC_W(8),  .CNT_W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle on the 16-bit instance, then sample 1 time unit after the edge.
   task automatic step16(input logic v, input logic [7:0] p, input logic l);
      b16.in_valid = v;
      b16.in_prod  = p;
      b16.in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic step8(input logic v, input logic [7:0] p, input logic l);
      b8.in_valid = v;
      b8.in_prod  = p;
      b8.in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      b16.out_ready = 1'b1;
      b8.out_ready  = 1'b1;
      b8.in_valid   = 1'b0;
      b8.in_prod    = 8'h00;
      b8.in_last    = 1'b0;
      step16(1'b1, 8'h11, 1'b1);
      step16(1'b1, 8'h11, 1'b1);
      rst = 1'b0;
      b16.in_valid = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.out_acc !== 16'h0 || b16.out_cnt !== 8'h0 || b16.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b acc=%h cnt=%h ovf=%b, expected all 0",
                  b16.out_valid, b16.out_acc, b16.out_cnt, b16.out_ovf);
      end
      checks++;
      if (b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", b16.in_ready);
      end
      step16(1'b0, 8'h00, 1'b0);
      checks++;
      if (b16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_beat_dropped: got out_valid=%b expected 0", b16.out_valid);
      end
   endtask

   task automatic test_basic();
      b16.out_ready = 1'b1;
      step16(1'b1, 8'h03, 1'b0);
      step16(1'b1, 8'h05, 1'b0);
      step16(1'b1, 8'h02, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd10 || b16.out_cnt !== 8'd3 || b16.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_sum: got valid=%b acc=%0d cnt=%0d ovf=%b, expected 1/10/3/0",
                  b16.out_valid, b16.out_acc, b16.out_cnt, b16.out_ovf);
      end
      step16(1'b0, 8'h00, 1'b0);
      checks++;
      if (b16.out_valid !== 1'b0 || b16.out_acc !== 16'd10) begin
         errors++;
         $display("FAIL basic_consume: got valid=%b acc=%0d, expected 0/10 (stale)",
                  b16.out_valid, b16.out_acc);
      end
   endtask

   task automatic test_negative();
      logic [15:0] exp_fc;
      logic [15:0] exp_80;
`ifdef DRUM_ONES_FIX_EN
      exp_fc = 16'hFFFD;
      exp_80 = 16'hFF81;
`else
      exp_fc = 16'hFFFC;
      exp_80 = 16'hFF80;
`endif
      step16(1'b1, 8'hFC, 1'b1);
      checks++;
      if (b16.out_acc !== exp_fc || b16.out_cnt !== 8'd1 || b16.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL neg_fc: got acc=%h cnt=%0d valid=%b, expected acc=%h cnt=1 valid=1",
                  b16.out_acc, b16.out_cnt, b16.out_valid, exp_fc);
      end
      step16(1'b1, 8'h80, 1'b1);
      checks++;
      if (b16.out_acc !== exp_80 || b16.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL neg_80: got acc=%h ovf=%b, expected acc=%h ovf=0", b16.out_acc, b16.out_ovf, exp_80);
      end
      step16(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_saturation();
      step8(1'b1, 8'h7F, 1'b0);
      step8(1'b1, 8'h7F, 1'b0);
      step8(1'b1, 8'h01, 1'b1);
      checks++;
      if (b8.out_acc !== 8'h7F || b8.out_ovf !== 1'b1 || b8.out_cnt !== 8'd3) begin
         errors++;
         $display("FAIL sat_pos: got acc=%h ovf=%b cnt=%0d, expected 7f/1/3", b8.out_acc, b8.out_ovf, b8.out_cnt);
      end
      step8(1'b1, 8'h01, 1'b1);
      checks++;
      if (b8.out_acc !== 8'h01 || b8.out_ovf !== 1'b0 || b8.out_cnt !== 8'd1) begin
         errors++;
         $display("FAIL sat_clear: got acc=%h ovf=%b cnt=%0d, expected 01/0/1", b8.out_acc, b8.out_ovf, b8.out_cnt);
      end
      step8(1'b1, 8'h80, 1'b0);
      step8(1'b1, 8'h80, 1'b1);
      checks++;
      if (b8.out_acc !== 8'h80 || b8.out_ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg: got acc=%h ovf=%b, expected 80/1", b8.out_acc, b8.out_ovf);
      end
      step8(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_backpressure();
      b16.out_ready = 1'b0;
      step16(1'b1, 8'h07, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd7) begin
         errors++;
         $display("FAIL bp_load: got valid=%b acc=%0d, expected 1/7", b16.out_valid, b16.out_acc);
      end
      for (int i = 0; i < 5; i++) begin
         b16.in_valid = 1'b1;
         b16.in_prod  = 8'h09;
         b16.in_last  = 1'b1;
         #1;
         checks++;
         if (b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1 || b16.out_acc !== 16'd7 || b16.out_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bp_stall[%0d]: got in_ready=%b valid=%b acc=%0d cnt=%0d, expected 0/1/7/1",
                     i, b16.in_ready, b16.out_valid, b16.out_acc, b16.out_cnt);
         end
         @(posedge clk);
         #1;
      end
      b16.out_ready = 1'b1;
      b16.in_prod   = 8'h04;
      #1;
      checks++;
      if (b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_comb: got in_ready=%b expected 1", b16.in_ready);
      end
      step16(1'b1, 8'h04, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd4 || b16.out_cnt !== 8'd1) begin
         errors++;
         $display("FAIL bp_reload: got valid=%b acc=%0d cnt=%0d, expected 1/4/1",
                  b16.out_valid, b16.out_acc, b16.out_cnt);
      end
      step16(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      b16.out_ready = 1'b1;
      step16(1'b1, 8'h01, 1'b0);
      b16.in_valid = 1'b1;
      b16.in_prod  = 8'h02;
      b16.in_last  = 1'b1;
      #1;
      checks++;
      if (b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready0: got %b expected 1", b16.in_ready);
      end
      step16(1'b1, 8'h02, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd3 || b16.out_cnt !== 8'd2) begin
         errors++;
         $display("FAIL b2b_first: got valid=%b acc=%0d cnt=%0d, expected 1/3/2",
                  b16.out_valid, b16.out_acc, b16.out_cnt);
      end
      b16.in_prod = 8'h03;
      #1;
      checks++;
      if (b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready1: got %b expected 1", b16.in_ready);
      end
      step16(1'b1, 8'h03, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd3 || b16.out_cnt !== 8'd1) begin
         errors++;
         $display("FAIL b2b_second: got valid=%b acc=%0d cnt=%0d, expected 1/3/1",
                  b16.out_valid, b16.out_acc, b16.out_cnt);
      end
      step16(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_count_saturation();
      b16.out_ready = 1'b1;
      for (int i = 0; i < 299; i++) begin
         step16(1'b1, 8'h00, 1'b0);
      end
      step16(1'b1, 8'h01, 1'b1);
      checks++;
      if (b16.out_cnt !== 8'hFF || b16.out_acc !== 16'd1) begin
         errors++;
         $display("FAIL cnt_sat: got cnt=%0d acc=%0d, expected 255/1", b16.out_cnt, b16.out_acc);
      end
      step16(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_mid_reset();
      b16.out_ready = 1'b1;
      step16(1'b1, 8'h01, 1'b0);
      step16(1'b1, 8'h02, 1'b0);
      rst = 1'b1;
      step16(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.out_acc !== 16'h0 || b16.out_cnt !== 8'h0 || b16.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got valid=%b acc=%h cnt=%h ovf=%b, expected all 0",
                  b16.out_valid, b16.out_acc, b16.out_cnt, b16.out_ovf);
      end
      step16(1'b1, 8'h06, 1'b1);
      checks++;
      if (b16.out_valid !== 1'b1 || b16.out_acc !== 16'd6 || b16.out_cnt !== 8'd1) begin
         errors++;
         $display("FAIL midrst_next: got valid=%b acc=%0d cnt=%0d, expected 1/6/1",
                  b16.out_valid, b16.out_acc, b16.out_cnt);
      end
      b16.out_ready = 1'b0;
      step16(1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      step16(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      checks++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pending: got valid=%b in_ready=%b, expected 0/1", b16.out_valid, b16.in_ready);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      b16.in_valid = 1'b0;
      b16.in_prod  = 8'h00;
      b16.in_last  = 1'b0;
      b16.out_ready = 1'b0;
      b8.in_valid  = 1'b0;
      b8.in_prod   = 8'h00;
      b8.in_last   = 1'b0;
      b8.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_negative();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_count_saturation();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
